// File: rtl/tm_pkg.sv
// tm_pkg -- shared definitions for the test_monitor block.
//
// Holds the FSM state encoding and the default parameter values used by
// test_monitor and tm_counter. Nothing else is defined locally in those
// files; anything shared lives here.

package tm_pkg;

  // Monitor FSM states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_CONFIRM = 3'd2,
    ST_PASS    = 3'd3,
    ST_FAIL    = 3'd4
  } tm_state_e;

  // Default parameter values.
  localparam int DEF_STABLE_CYCLES  = 4;
  localparam int DEF_TIMEOUT_CYCLES = 1000;
  localparam int DEF_CNT_W          = 32;

  // Width of the inline stability counter (STABLE_CYCLES tops out at 255).
  localparam int STAB_W = 8;

endpackage : tm_pkg

// File: rtl/tm_counter.sv
// tm_counter -- clearable, enabled up-counter.
//
// Ports:
//   clk      in   clock
//   reset_n  in   asynchronous active-low reset (count -> 0)
//   clr      in   synchronous clear; wins over en
//   en       in   increment by one this edge
//   count    out  [W-1:0] current count (registered)

module tm_counter
  import tm_pkg::*;
#(
  parameter int W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

endmodule : tm_counter

// File: rtl/test_monitor.sv
// test_monitor -- supervises one run of an upstream core stage.
//
// A run starts on start (from IDLE, PASS or FAIL). While the run is active
// the monitor counts clock edges in `cycles` and waits for `passed` to be
// seen high on STABLE_CYCLES consecutive edges, which ends the run with a
// pass. abort or reaching TIMEOUT_CYCLES busy edges ends the run with a fail.
// On a single edge a pass completion beats abort, and abort beats timeout.
// The result is sticky until the next start or reset.
//
// Parameters:
//   STABLE_CYCLES   consecutive high samples of passed for a pass (1..255)
//   TIMEOUT_CYCLES  busy edges allowed before fail (> STABLE_CYCLES)
//   CNT_W           width of the cycles counter
//
// Ports:
//   clk        in   single clock
//   reset_n    in   asynchronous active-low reset
//   start      in   begin a monitored run (ignored while busy)
//   abort      in   force fail of an active run (ignored when not busy)
//   passed     in   completion flag from upstream (ignored when not busy)
//   busy       out  run in progress (RUN or CONFIRM)
//   done       out  run finished, sticky (PASS or FAIL)
//   pass       out  run finished with pass, sticky
//   fail       out  run finished with fail, sticky
//   cycles     out  [CNT_W-1:0] busy edges since start was accepted
//   dbg_state  out  current FSM state, for observation only
//
// Build option:
//   TEST_MONITOR_TRACE_EN  when defined, prints a line on entry to PASS/FAIL
//                          (simulation only; no effect on logic).
//
// Handshake: start/abort/passed are level-sampled on every rising edge; there
// is no valid/ready pairing. A start seen while idle or finished is accepted
// on that edge (busy rises after it); start while busy is dropped.

module test_monitor
  import tm_pkg::*;
#(
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic             passed,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] cycles,
  output tm_state_e        dbg_state
);

  // Stability count value at which one more high sample completes the pass.
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  // cycles value on the edge that times the run out.
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  tm_state_e         state, state_next;
  logic [STAB_W-1:0] stab, stab_next;
  logic              cnt_clr, cnt_en;
  logic              timeout_hit;
  logic              abort_hit;

  assign timeout_hit = (cycles == TO_LAST);

  // ---------------------------------------------------------------------------
  // State and stability count registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      stab  <= '0;
    end else begin
      state <= state_next;
      stab  <= stab_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    stab_next  = stab;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    abort_hit  = 1'b0;

    unique case (state)
      ST_IDLE, ST_PASS, ST_FAIL: begin
        if (start) begin
          state_next = ST_RUN;
          stab_next  = '0;
          cnt_clr    = 1'b1;
        end
      end

      ST_RUN: begin
        cnt_en = 1'b1;
        // With STABLE_CYCLES == 1 the first high sample is already a pass,
        // so it must be tested before abort/timeout.
        if (passed && (STABLE_CYCLES == 1)) begin
          state_next = ST_PASS;
          stab_next  = STAB_W'(1);
        end else if (abort) begin
          state_next = ST_FAIL;
          abort_hit  = 1'b1;
        end else if (timeout_hit) begin
          state_next = ST_FAIL;
        end else if (passed) begin
          state_next = ST_CONFIRM;
          stab_next  = STAB_W'(1);
        end
      end

      ST_CONFIRM: begin
        cnt_en = 1'b1;
        if (passed && (stab == STAB_LAST)) begin
          state_next = ST_PASS;
          stab_next  = stab + STAB_W'(1);
        end else if (abort) begin
          state_next = ST_FAIL;
          abort_hit  = 1'b1;
        end else if (timeout_hit) begin
          state_next = ST_FAIL;
        end else if (passed) begin
          stab_next  = stab + STAB_W'(1);
        end else begin
          state_next = ST_RUN;
          stab_next  = '0;
        end
      end

      default: begin
        state_next = ST_IDLE;
        stab_next  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Cycle counter
  // ---------------------------------------------------------------------------
  tm_counter #(
    .W (CNT_W)
  ) u_cycles (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .count   (cycles)
  );

  // ---------------------------------------------------------------------------
  // Registered status outputs, decoded from the next state so they line up
  // with the state register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      fail <= 1'b0;
    end else begin
      busy <= (state_next == ST_RUN) || (state_next == ST_CONFIRM);
      done <= (state_next == ST_PASS) || (state_next == ST_FAIL);
      pass <= (state_next == ST_PASS);
      fail <= (state_next == ST_FAIL);
    end
  end

  assign dbg_state = state;

  // ---------------------------------------------------------------------------
  // Optional run-result trace. cycles increments on the finishing edge, so the
  // reported value is the count after that edge.
  // ---------------------------------------------------------------------------
`ifdef TEST_MONITOR_TRACE_EN
  always @(posedge clk) begin
    if (reset_n) begin
      if ((state_next == ST_PASS) && (state != ST_PASS)) begin
        $write("PASSED after %0d cycles\n", cycles + CNT_W'(1));
      end else if ((state_next == ST_FAIL) && (state != ST_FAIL)) begin
        if (abort_hit) begin
          $write("FAILED (abort) at %0d\n", cycles + CNT_W'(1));
        end else begin
          $write("FAILED (timeout) at %0d\n", cycles + CNT_W'(1));
        end
      end
    end
  end
`else
  // abort_hit only feeds the trace; keep it referenced in the default build.
  logic unused_abort_hit;
  assign unused_abort_hit = abort_hit;
`endif

endmodule : test_monitor

// File: tb/tb_test_monitor.sv
// tb_test_monitor -- directed self-checking bench for test_monitor
// (default parameters: STABLE_CYCLES=4, TIMEOUT_CYCLES=1000, CNT_W=32).
//
// Edge numbering: "edge 0" is the rising edge on which start is sampled high;
// edge k is the k-th rising edge after it. Inputs change and outputs are
// sampled 1 time unit after a rising edge.

`timescale 1ns/1ps

module tb_test_monitor;
  import tm_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, abort, passed;
  logic        busy, done, pass, fail;
  logic [31:0] cycles;
  tm_state_e   dbg_state;

  always #5 clk = ~clk;

  test_monitor #(
    .STABLE_CYCLES  (4),
    .TIMEOUT_CYCLES (1000),
    .CNT_W          (32)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .passed    (passed),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail      (fail),
    .cycles    (cycles),
    .dbg_state (dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Status bundle {busy, done, pass, fail}.
  logic [3:0] st;
  assign st = {busy, done, pass, fail};

  localparam logic [3:0] S_IDLE = 4'b0000;
  localparam logic [3:0] S_BUSY = 4'b1000;
  localparam logic [3:0] S_PASS = 4'b0110;
  localparam logic [3:0] S_FAIL = 4'b0101;

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept start on the next edge (edge 0), then leave start low.
  task automatic do_start();
    start  = 1'b1;
    abort  = 1'b0;
    passed = 1'b0;
    step();
    start  = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    passed  = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b1;
    abort   = 1'b0;
    passed  = 1'b1;
    #3;
    for (int i = 0; i < 3; i++) step();
    n_cmp++;
    if (st !== S_IDLE) begin
      n_err++; $display("FAIL reset_status got=%b exp=%b", st, S_IDLE);
    end
    n_cmp++;
    if (cycles !== 32'd0) begin
      n_err++; $display("FAIL reset_cycles got=%0d exp=0", cycles);
    end
    n_cmp++;
    if (dbg_state !== ST_IDLE) begin
      n_err++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE);
    end
    start   = 1'b0;
    passed  = 1'b0;
    reset_n = 1'b1;
    step();
    n_cmp++;
    if (st !== S_IDLE) begin
      n_err++; $display("FAIL reset_release_idle got=%b exp=%b", st, S_IDLE);
    end
  endtask

  task automatic test_clean_pass();
    do_start();
    n_cmp++;
    if (st !== S_BUSY || cycles !== 32'd0) begin
      n_err++; $display("FAIL start_accept st=%b cyc=%0d exp st=%b cyc=0", st, cycles, S_BUSY);
    end
    for (int e = 1; e <= 13; e++) begin
      passed = (e >= 10);
      step();
      if (e == 12) begin
        n_cmp++;
        if (st !== S_BUSY || cycles !== 32'd12) begin
          n_err++; $display("FAIL clean_pre_pass st=%b cyc=%0d exp st=%b cyc=12", st, cycles, S_BUSY);
        end
      end
    end
    passed = 1'b0;
    n_cmp++;
    if (st !== S_PASS || cycles !== 32'd13) begin
      n_err++; $display("FAIL clean_pass st=%b cyc=%0d exp st=%b cyc=13", st, cycles, S_PASS);
    end
  endtask

  // Result is sticky: passed, abort toggling and idle edges change nothing.
  task automatic test_hold();
    for (int i = 0; i < 6; i++) begin
      passed = i[0];
      abort  = ~i[0];
      step();
    end
    passed = 1'b0;
    abort  = 1'b0;
    n_cmp++;
    if (st !== S_PASS || cycles !== 32'd13) begin
      n_err++; $display("FAIL pass_hold st=%b cyc=%0d exp st=%b cyc=13", st, cycles, S_PASS);
    end
  endtask

  // Glitch in passed restarts the stability count; start while busy ignored.
  task automatic test_glitch();
    do_start();
    for (int e = 1; e <= 12; e++) begin
      passed = ((e >= 5) && (e <= 7)) || ((e >= 9) && (e <= 12));
      start  = (e == 3);
      step();
      if (e == 3) begin
        n_cmp++;
        if (cycles !== 32'd3 || st !== S_BUSY) begin
          n_err++; $display("FAIL start_ignored_busy st=%b cyc=%0d exp st=%b cyc=3", st, cycles, S_BUSY);
        end
      end
      if (e == 8) begin
        n_cmp++;
        if (st !== S_BUSY) begin
          n_err++; $display("FAIL glitch_no_early_pass got=%b exp=%b", st, S_BUSY);
        end
      end
      if (e == 11) begin
        n_cmp++;
        if (st !== S_BUSY || cycles !== 32'd11) begin
          n_err++; $display("FAIL glitch_edge11 st=%b cyc=%0d exp st=%b cyc=11", st, cycles, S_BUSY);
        end
      end
    end
    passed = 1'b0;
    start  = 1'b0;
    n_cmp++;
    if (st !== S_PASS || cycles !== 32'd12) begin
      n_err++; $display("FAIL glitch_pass st=%b cyc=%0d exp st=%b cyc=12", st, cycles, S_PASS);
    end
  endtask

  task automatic test_timeout();
    do_start();
    for (int e = 1; e <= 1000; e++) begin
      step();
      if (e == 999) begin
        n_cmp++;
        if (st !== S_BUSY || cycles !== 32'd999) begin
          n_err++; $display("FAIL timeout_edge999 st=%b cyc=%0d exp st=%b cyc=999", st, cycles, S_BUSY);
        end
      end
    end
    n_cmp++;
    if (st !== S_FAIL || cycles !== 32'd1000) begin
      n_err++; $display("FAIL timeout st=%b cyc=%0d exp st=%b cyc=1000", st, cycles, S_FAIL);
    end
    step();
    step();
    n_cmp++;
    if (st !== S_FAIL || cycles !== 32'd1000) begin
      n_err++; $display("FAIL timeout_hold st=%b cyc=%0d exp st=%b cyc=1000", st, cycles, S_FAIL);
    end
  endtask

  task automatic test_abort();
    do_start();
    for (int e = 1; e <= 20; e++) begin
      abort = (e == 20);
      step();
    end
    abort = 1'b0;
    n_cmp++;
    if (st !== S_FAIL || cycles !== 32'd20) begin
      n_err++; $display("FAIL abort st=%b cyc=%0d exp st=%b cyc=20", st, cycles, S_FAIL);
    end
  endtask

  // Abort with passed high but not yet complete still fails.
  task automatic test_abort_in_confirm();
    do_start();
    for (int e = 1; e <= 6; e++) begin
      passed = (e >= 4);
      abort  = (e == 6);
      step();
    end
    passed = 1'b0;
    abort  = 1'b0;
    n_cmp++;
    if (st !== S_FAIL || cycles !== 32'd6) begin
      n_err++; $display("FAIL abort_confirm st=%b cyc=%0d exp st=%b cyc=6", st, cycles, S_FAIL);
    end
  endtask

  task automatic test_collision_abort();
    do_start();
    for (int e = 1; e <= 13; e++) begin
      passed = (e >= 10);
      abort  = (e == 13);
      step();
    end
    passed = 1'b0;
    abort  = 1'b0;
    n_cmp++;
    if (st !== S_PASS || cycles !== 32'd13) begin
      n_err++; $display("FAIL collide_abort st=%b cyc=%0d exp st=%b cyc=13", st, cycles, S_PASS);
    end
  endtask

  task automatic test_collision_timeout();
    do_start();
    for (int e = 1; e <= 1000; e++) begin
      passed = (e >= 997);
      step();
    end
    passed = 1'b0;
    n_cmp++;
    if (st !== S_PASS || cycles !== 32'd1000) begin
      n_err++; $display("FAIL collide_timeout st=%b cyc=%0d exp st=%b cyc=1000", st, cycles, S_PASS);
    end
  endtask

  task automatic test_midrun_reset();
    do_start();
    for (int e = 1; e <= 49; e++) step();
    n_cmp++;
    if (st !== S_BUSY || cycles !== 32'd49) begin
      n_err++; $display("FAIL midrun_pre st=%b cyc=%0d exp st=%b cyc=49", st, cycles, S_BUSY);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (st !== S_IDLE || cycles !== 32'd0 || dbg_state !== ST_IDLE) begin
      n_err++; $display("FAIL midrun_async st=%b cyc=%0d state=%0d exp st=%b cyc=0", st, cycles, dbg_state, S_IDLE);
    end
    step();
    reset_n = 1'b1;
    test_clean_pass();
  endtask

  // Start directly from PASS begins a fresh run.
  task automatic test_back_to_back();
    do_start();
    n_cmp++;
    if (st !== S_BUSY || cycles !== 32'd0) begin
      n_err++; $display("FAIL b2b_restart st=%b cyc=%0d exp st=%b cyc=0", st, cycles, S_BUSY);
    end
    step();
    n_cmp++;
    if (cycles !== 32'd1) begin
      n_err++; $display("FAIL b2b_count got=%0d exp=1", cycles);
    end
    do_reset();
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_clean_pass();
    test_hold();
    test_glitch();
    test_timeout();
    test_abort();
    test_abort_in_confirm();
    test_collision_abort();
    test_collision_timeout();
    test_midrun_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_test_monitor

// File: doc/test_monitor.md
TEST_MONITOR -- requirements
Module: test_monitor

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive high samples of passed required to declare pass; legal range 1..255.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000: busy cycles allowed before fail; SHALL exceed STABLE_CYCLES.
REQ-003 Parameter CNT_W, default 32: width of the cycles counter.
REQ-004 clk  input  1  single clock for all state.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  request to begin a monitored run.
REQ-007 abort  input  1  force fail of an active run.
REQ-008 passed  input  1  completion flag from the core stage upstream.
REQ-009 busy  output  1  run in progress.
REQ-010 done  output  1  run finished (pass or fail), sticky.
REQ-011 pass  output  1  run finished with pass, sticky.
REQ-012 fail  output  1  run finished with fail, sticky.
REQ-013 cycles  output  CNT_W  busy edges since start acceptance.

Function
REQ-014 FSM states IDLE, RUN, CONFIRM, PASS, FAIL; all outputs registered and decoded from state (busy = RUN|CONFIRM, done = PASS|FAIL).
REQ-015 IDLE/PASS/FAIL: start=1 -> RUN, cycles cleared to 0, stability counter cleared; start ignored in RUN/CONFIRM.
REQ-016 Each edge in RUN/CONFIRM increments cycles by 1; cycles holds its value in IDLE/PASS/FAIL.
REQ-017 RUN: passed=1 -> CONFIRM with stability count 1; if STABLE_CYCLES==1, -> PASS directly.
REQ-018 CONFIRM: passed=1 with count==STABLE_CYCLES-1 -> PASS; passed=1 otherwise -> count+1; passed=0 -> RUN, count 0.
REQ-019 Timeout: in RUN/CONFIRM, an edge with cycles==TIMEOUT_CYCLES-1 -> FAIL (cycles becomes TIMEOUT_CYCLES).
REQ-020 abort=1 in RUN/CONFIRM -> FAIL next edge; abort ignored elsewhere.
REQ-021 Priority on the same edge: pass completion > abort > timeout.
REQ-022 PASS/FAIL hold until start or reset; passed ignored outside RUN/CONFIRM.

Reset
REQ-023 reset_n low asynchronously forces IDLE, cycles=0, stability count 0, busy=done=pass=fail=0, including mid-run.
REQ-024 Release of reset_n is not synchronised internally; the first edge after release evaluates start normally.

Configuration
REQ-025 Macro TEST_MONITOR_TRACE_EN defined: on entry to PASS print "PASSED after <cycles> cycles", on entry to FAIL print "FAILED (timeout|abort) at <cycles>" via $write; simulation only.
REQ-026 Macro undefined: no display code is compiled; logic and outputs are unchanged.

Structure
REQ-027 Shared package (tm_pkg) holds the state encoding constants and the default parameter values; no other block-local definitions.
REQ-028 One sub-module, tm_counter (clearable, enabled up-counter of width CNT_W), instantiated for cycles; stability count stays inline.

Verification
REQ-029 Reset: reset_n low -> busy=done=pass=fail=0, cycles=0; start held during reset has no effect.
REQ-030 Clean pass: start accepted at edge 0, passed sampled high at edges 10-13 -> PASS after edge 13, cycles=13, done=pass=1, fail=0.
REQ-031 Glitch: passed high at edges 5-7, low at 8, high at 9-12 -> no pass until after edge 12, cycles=12.
REQ-032 Timeout: start, passed held 0 -> FAIL after edge 1000, cycles=1000, done=fail=1, pass=0.
REQ-033 Collisions: abort at edge 20 -> FAIL, cycles=20; passed 4th high sample on the same edge as abort or timeout -> PASS.
REQ-034 Mid-run reset at edge 50 -> immediate IDLE, cycles=0; restart then passes normally with cycles counted from 0.
